adc_scan: RTL and testbench
===========================

ADC_SCAN -- requirements
Module: adc_scan

Interface
REQ-001 Parameter PERIOD, default 50000: clk cycles between scan-start ticks, 2..2^24-1.
REQ-002 Parameter TIMEOUT, default 255: clk cycles allowed from issue to ADC result, 1..255.
REQ-003 clk  in  1  sole clock; all logic on posedge clk.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 enable  in  1  periodic scanning enabled.
REQ-006 ch_mask  in  8  per-channel scan enable, bit n = channel n.
REQ-007 adc_in_data  out  24  command to ADC block; [7:0] address, [2:0] channel.
REQ-008 adc_in_wr  out  1  one-cycle command strobe to ADC block.
REQ-009 adc_out_data  in  24  ADC result; [23:16] echoed address, [9:0] sample.
REQ-010 adc_out_wr  in  1  one-cycle result strobe from ADC block.
REQ-011 host_data, host_wr  in  24, 1  one-shot host conversion request.
REQ-012 host_busy  out  1  high while a host request is queued or in flight.
REQ-013 host_rsp_data, host_rsp_wr  out  24, 1  host result forwarded unmodified, one-cycle strobe.
REQ-014 rd_addr  in  3 ; rd_data  out  10 ; rd_valid  out  1  result table read port.
REQ-015 scan_done  out  1  one-cycle pulse at end of each scan.
REQ-016 err_timeout, err_overrun  out  1 each  sticky error flags; err_clr  in  1  clears both.

Function
REQ-017 FSM states IDLE, ISSUE, WAIT, NEXT; exactly one ADC command outstanding at any time.
REQ-018 Tick counter counts 0..PERIOD-1 while enable=1, held at 0 when enable=0; terminal count sets scan_pending.
REQ-019 Tick while scan_pending already set or scan active SHALL set err_overrun; pending stays single.
REQ-020 IDLE: host request queued -> ISSUE(host); else scan_pending -> clear pending, channel pointer=0, NEXT; host wins on same-cycle conflict.
REQ-021 NEXT: advance pointer to lowest enabled channel >= pointer, -> ISSUE; none left -> pulse scan_done, -> IDLE; ch_mask=0 gives scan_done 2 cycles after start.
REQ-022 ch_mask sampled once per channel selection in NEXT; mid-scan changes affect only unvisited channels.
REQ-023 ISSUE: adc_in_wr=1 for exactly one cycle, adc_in_data={16'h0, 8'h80|ch} for scan or host_data for host, -> WAIT.
REQ-024 WAIT: adc_out_wr -> scan: store adc_out_data[9:0] to table[ch], set valid[ch]; host: host_rsp_data=adc_out_data, host_rsp_wr=1 next cycle, clear host_busy.
REQ-025 WAIT exit: scan -> NEXT with pointer+1 (pointer 7 -> scan end); host -> IDLE.
REQ-026 WAIT timeout counter reaching TIMEOUT with no adc_out_wr: set err_timeout, table entry and valid unchanged, host request dropped (no host_rsp_wr, host_busy cleared).
REQ-027 adc_out_wr outside WAIT SHALL be ignored.
REQ-028 host_wr while host_busy=1 ignored; host_wr when idle captures host_data and sets host_busy next cycle.
REQ-029 rd_data/rd_valid registered: reflect table[rd_addr]/valid[rd_addr] one cycle after rd_addr; same-cycle store returns new value one cycle later.
REQ-030 enable=0 clears scan_pending; an in-progress scan completes normally.
REQ-031 err_clr has priority over same-cycle error set.

Reset
REQ-032 rst: FSM IDLE, counters 0, scan_pending=0, host_busy=0, valid[7:0]=0, table=0, all strobes 0, err flags 0, adc_in_data=0, host_rsp_data=0, rd_data=0, rd_valid=0.
REQ-033 rst mid-WAIT abandons the command; a later ADC result is ignored per REQ-027.

Configuration
REQ-034 Macro ADC_SCAN_AVG_EN defined: each scanned channel converted 4 times consecutively, 12-bit sum, table stores sum[11:2]; any sample timeout discards the channel's sum.
REQ-035 ADC_SCAN_AVG_EN undefined: one conversion per channel, stored directly; host requests unaffected in both builds.

Structure
REQ-036 Package adc_scan_pkg holds FSM state encoding, SCAN_TAG=8'h80, channel count 8, sample width 10, command width 24.
REQ-037 Sub-module adc_scan_timer implements the PERIOD tick counter and overrun detect.

Verification
REQ-038 PERIOD=100, ch_mask=8'h05, ADC model returns 10'h155/10'h2AA -> commands 8'h80, 8'h82 only; table[0]=155, table[2]=2AA, valid=8'h05, one scan_done.
REQ-039 host_wr data 24'h000003 same cycle as tick -> host command issued first; host_rsp_wr carries model result; scan follows.
REQ-040 ADC model silent on channel 1, TIMEOUT=20 -> err_timeout at cycle 20 of WAIT, valid[1]=0, scan continues to channel 2.
REQ-041 PERIOD=10, 8 channels, ADC latency 30 -> err_overrun set; err_clr clears it.
REQ-042 ADC_SCAN_AVG_EN, samples 100,101,102,103 on channel 4 -> table[4]=101, 4 adc_in_wr pulses.
REQ-043 rst asserted in WAIT, late adc_out_wr -> no table write, all outputs at reset values.

Source files
------------

// File: rtl/adc_scan_pkg.sv
// Shared encodings and constants for the periodic ADC channel scanner.
package adc_scan_pkg;
  localparam int NUM_CH = 8;
  localparam int SAMP_W = 10;
  localparam int CMD_W  = 24;
  localparam logic [7:0] SCAN_TAG = 8'h80;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_NEXT} state_e;

  // Lowest enabled channel at or above ptr; returns NUM_CH when none remain.
  function automatic logic [3:0] next_ch(input logic [NUM_CH-1:0] mask, input logic [3:0] ptr);
    logic [3:0] res;
    res = 4'(NUM_CH);
    for (int i = NUM_CH-1; i >= 0; i--)
      if (mask[i] && (4'(i) >= ptr)) res = 4'(i);
    return res;
  endfunction
endpackage

// File: rtl/adc_scan_if.sv
// ADC command/result and host request/response signals of the scanner.
interface adc_scan_if;
  import adc_scan_pkg::*;
  logic [CMD_W-1:0] adc_in_data;
  logic             adc_in_wr;
  logic [CMD_W-1:0] adc_out_data;
  logic             adc_out_wr;
  logic [CMD_W-1:0] host_data;
  logic             host_wr;
  logic             host_busy;
  logic [CMD_W-1:0] host_rsp_data;
  logic             host_rsp_wr;

  modport master (output adc_in_data, adc_in_wr, host_busy, host_rsp_data, host_rsp_wr,
                  input  adc_out_data, adc_out_wr, host_data, host_wr);
  modport slave  (input  adc_in_data, adc_in_wr, host_busy, host_rsp_data, host_rsp_wr,
                  output adc_out_data, adc_out_wr, host_data, host_wr);
endinterface

// File: rtl/adc_scan_timer.sv
// Scan-start tick generator: PERIOD counter, single pending flag and overrun detect.
module adc_scan_timer #(
  parameter int PERIOD = 50000
) (
  input  logic clk,
  input  logic rst,
  input  logic enable_i,
  input  logic scan_act_i,
  input  logic pend_clr_i,
  output logic pending_o,
  output logic overrun_o
);
  logic [23:0] cnt_q, cnt_d;
  logic        pend_q, pend_d;
  logic        tick;

  assign tick = enable_i && (cnt_q == 24'(PERIOD-1));

  always_comb begin
    cnt_d  = (enable_i && !tick) ? cnt_q + 24'd1 : '0;
    pend_d = pend_q;
    if (!enable_i)       pend_d = 1'b0;
    else if (tick)       pend_d = 1'b1;
    else if (pend_clr_i) pend_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      pend_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      pend_q <= pend_d;
    end
  end

  assign pending_o = pend_q;
  assign overrun_o = tick && (pend_q || scan_act_i);
endmodule

// File: rtl/adc_scan.sv
// Periodic 8-channel ADC scanner with host one-shot requests and a result table.
// Define ADC_SCAN_AVG_EN to average four conversions per scanned channel.
module adc_scan
  import adc_scan_pkg::*;
#(
  parameter int PERIOD  = 50000,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic [NUM_CH-1:0] ch_mask,
  adc_scan_if.master        bus,
  input  logic [2:0]        rd_addr,
  output logic [SAMP_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              scan_done,
  output logic              err_timeout,
  output logic              err_overrun,
  input  logic              err_clr
);
  state_e            state_q, state_d;
  logic [3:0]        ptr_q, ptr_d, nxt;
  logic              host_op_q, host_op_d;
  logic              host_busy_q;
  logic [CMD_W-1:0]  host_data_q, rsp_data_q;
  logic              rsp_wr_q;
  logic [7:0]        to_cnt_q;
  logic [SAMP_W-1:0] tbl_q [NUM_CH];
  logic [NUM_CH-1:0] vld_q;
  logic [SAMP_W-1:0] rd_data_q, wr_val;
  logic              rd_valid_q, err_to_q, err_ov_q;
  logic              pending, overrun, pend_clr, scan_act;
  logic              got, to_hit, last_conv, wr_en, rd_hit;

  adc_scan_timer #(.PERIOD(PERIOD)) u_timer (
    .clk        (clk),
    .rst        (rst),
    .enable_i   (enable),
    .scan_act_i (scan_act),
    .pend_clr_i (pend_clr),
    .pending_o  (pending),
    .overrun_o  (overrun)
  );

  assign scan_act = (state_q != S_IDLE) && !host_op_q;
  assign nxt      = next_ch(ch_mask, ptr_q);
  assign got      = (state_q == S_WAIT) && bus.adc_out_wr;
  assign to_hit   = (state_q == S_WAIT) && !bus.adc_out_wr && (to_cnt_q == 8'(TIMEOUT-1));
  assign wr_en    = got && !host_op_q && last_conv;
  assign rd_hit   = wr_en && (ptr_q[2:0] == rd_addr);

`ifdef ADC_SCAN_AVG_EN
  logic [1:0]  cnv_q;
  logic [11:0] sum_q, sum_nx;
  assign sum_nx    = sum_q + 12'(bus.adc_out_data[SAMP_W-1:0]);
  assign last_conv = (cnv_q == 2'd3);
  assign wr_val    = sum_nx[11:2];
  // Entering NEXT starts a fresh channel, which also discards a timed-out partial sum.
  always_ff @(posedge clk) begin
    if (rst || state_q == S_NEXT) begin
      cnv_q <= '0;
      sum_q <= '0;
    end else if (got && !host_op_q) begin
      cnv_q <= cnv_q + 2'd1;
      sum_q <= sum_nx;
    end
  end
`else
  assign last_conv = 1'b1;
  assign wr_val    = bus.adc_out_data[SAMP_W-1:0];
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      ptr_q     <= '0;
      host_op_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      host_op_q <= host_op_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    host_op_d = host_op_q;
    pend_clr  = 1'b0;
    case (state_q)
      S_IDLE:
        if (host_busy_q) begin
          host_op_d = 1'b1;
          state_d   = S_ISSUE;
        end else if (pending) begin
          host_op_d = 1'b0;
          pend_clr  = 1'b1;
          ptr_d     = '0;
          state_d   = S_NEXT;
        end
      S_NEXT: begin
        ptr_d   = nxt;
        state_d = nxt[3] ? S_IDLE : S_ISSUE;
      end
      S_ISSUE: state_d = S_WAIT;
      S_WAIT:
        if (got || to_hit) begin
          if (host_op_q)              state_d = S_IDLE;
          else if (got && !last_conv) state_d = S_ISSUE;
          else begin
            ptr_d   = ptr_q + 4'd1;
            state_d = S_NEXT;
          end
        end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    bus.adc_in_wr   = 1'b0;
    bus.adc_in_data = '0;
    scan_done       = 1'b0;
    case (state_q)
      S_ISSUE: begin
        bus.adc_in_wr   = 1'b1;
        bus.adc_in_data = host_op_q ? host_data_q : {16'h0, SCAN_TAG | {5'b0, ptr_q[2:0]}};
      end
      S_NEXT:  scan_done = nxt[3];
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      host_busy_q <= 1'b0;
      host_data_q <= '0;
      rsp_data_q  <= '0;
      rsp_wr_q    <= 1'b0;
      to_cnt_q    <= '0;
      vld_q       <= '0;
      rd_data_q   <= '0;
      rd_valid_q  <= 1'b0;
      err_to_q    <= 1'b0;
      err_ov_q    <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) tbl_q[i] <= '0;
    end else begin
      if (!host_busy_q && bus.host_wr) begin
        host_busy_q <= 1'b1;
        host_data_q <= bus.host_data;
      end else if (host_op_q && (got || to_hit)) begin
        host_busy_q <= 1'b0;
      end
      rsp_wr_q <= got && host_op_q;
      if (got && host_op_q) rsp_data_q <= bus.adc_out_data;
      to_cnt_q <= (state_q == S_WAIT) ? to_cnt_q + 8'd1 : '0;
      if (wr_en) begin
        tbl_q[ptr_q[2:0]] <= wr_val;
        vld_q[ptr_q[2:0]] <= 1'b1;
      end
      // Bypass so a read colliding with a store returns the new entry.
      rd_data_q  <= rd_hit ? wr_val : tbl_q[rd_addr];
      rd_valid_q <= rd_hit || vld_q[rd_addr];
      err_to_q   <= !err_clr && (err_to_q || to_hit);
      err_ov_q   <= !err_clr && (err_ov_q || overrun);
    end
  end

  assign bus.host_busy     = host_busy_q;
  assign bus.host_rsp_data = rsp_data_q;
  assign bus.host_rsp_wr   = rsp_wr_q;
  assign rd_data           = rd_data_q;
  assign rd_valid          = rd_valid_q;
  assign err_timeout       = err_to_q;
  assign err_overrun       = err_ov_q;
endmodule

// File: tb/tb_adc_scan.sv
// Scoreboard bench for adc_scan: behavioural ADC model, expected-command/response queues,
// and a result-table reference rebuilt from the samples the ADC model hands out.
module tb_adc_scan;
  localparam int PERIOD  = 100;
  localparam int TIMEOUT = 20;
`ifdef ADC_SCAN_AVG_EN
  localparam int NCONV = 4;
`else
  localparam int NCONV = 1;
`endif

  logic       clk = 1'b0, rst = 1'b1, enable = 1'b0, err_clr = 1'b0;
  logic [7:0] ch_mask = 8'h00;
  logic [2:0] rd_addr = 3'd0;
  logic [9:0] rd_data;
  logic       rd_valid, scan_done, err_timeout, err_overrun;

  adc_scan_if bus();

  adc_scan #(.PERIOD(PERIOD), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .enable(enable), .ch_mask(ch_mask), .bus(bus),
    .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid), .scan_done(scan_done),
    .err_timeout(err_timeout), .err_overrun(err_overrun), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  int         checks = 0, errors = 0;
  logic [23:0] exp_cmd[$], exp_rsp[$];
  logic [9:0]  force_q[$];
  int         ref_tbl[8], acc[8], nacc[8];
  logic [7:0] ref_vld = 8'h00, silent = 8'h00;
  int         lat = 3, epoch = 0, cmd_cnt = 0, done_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ADC: answers every command after lat cycles, except scan commands to silent channels.
  initial begin : adc_model
    logic [23:0] cmd;
    logic [9:0]  smp;
    int          ep, ch;
    bus.adc_out_wr   = 1'b0;
    bus.adc_out_data = '0;
    forever begin
      @(negedge clk);
      bus.adc_out_wr = 1'b0;
      if (bus.adc_in_wr && !rst) begin
        cmd = bus.adc_in_data;
        ep  = epoch;
        ch  = int'(cmd[2:0]);
        if (cmd[7] && silent[ch]) begin
          acc[ch]  = 0;
          nacc[ch] = 0;
        end else begin
          smp = (cmd[7] && force_q.size() > 0) ? force_q.pop_front() : 10'($urandom_range(0, 1023));
          repeat (lat) @(negedge clk);
          bus.adc_out_data = {cmd[7:0], 6'h0, smp};
          bus.adc_out_wr   = 1'b1;
          if (ep == epoch) begin
            if (cmd[7]) begin
              acc[ch] += int'(smp);
              nacc[ch]++;
              if (nacc[ch] == NCONV) begin
                ref_tbl[ch] = acc[ch] / NCONV;
                ref_vld[ch] = 1'b1;
                acc[ch]     = 0;
                nacc[ch]    = 0;
              end
            end else begin
              exp_rsp.push_back({cmd[7:0], 6'h0, smp});
            end
          end
        end
      end
    end
  end

  initial begin : monitor
    forever begin
      @(negedge clk);
      if (bus.adc_in_wr) begin
        cmd_cnt++;
        if (exp_cmd.size() == 0) begin
          checks++; errors++;
          $display("FAIL adc_cmd_unexpected: got %0h expected none", bus.adc_in_data);
        end else check("adc_cmd", 32'(bus.adc_in_data), 32'(exp_cmd.pop_front()));
      end
      if (bus.host_rsp_wr) begin
        if (exp_rsp.size() == 0) begin
          checks++; errors++;
          $display("FAIL host_rsp_unexpected: got %0h expected none", bus.host_rsp_data);
        end else check("host_rsp", 32'(bus.host_rsp_data), 32'(exp_rsp.pop_front()));
      end
      if (scan_done) done_cnt++;
    end
  end

  task automatic push_scan(input logic [7:0] m);
    for (int c = 0; c < 8; c++)
      if (m[c]) repeat (silent[c] ? 1 : NCONV) exp_cmd.push_back({16'h0, 8'h80 | 8'(c)});
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (!scan_done && n < PERIOD + 8*NCONV*(TIMEOUT+4) + 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!scan_done) begin
      errors++;
      $display("FAIL %s: got no scan_done within %0d cycles expected pulse", name, n);
    end
    enable = 1'b0;
  endtask

  task automatic run_scan(input logic [7:0] m, input string name);
    ch_mask = m;
    push_scan(m);
    enable = 1'b1;
    @(negedge clk);
    wait_done(name);
  endtask

  task automatic wait_host(input string name);
    int n = 0;
    while (bus.host_busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    check({name, "_busy_clr"}, 32'(bus.host_busy), 32'd0);
  endtask

  task automatic check_table(input string name);
    for (int c = 0; c < 8; c++) begin
      rd_addr = 3'(c);
      @(negedge clk);
      check($sformatf("%s_data%0d", name, c), 32'(rd_data), 32'(ref_tbl[c]));
      check($sformatf("%s_valid%0d", name, c), 32'(rd_valid), 32'(ref_vld[c]));
    end
  endtask

  task automatic pulse_clr();
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
  endtask

  initial begin : stim
    int          d0, c0, n;
    logic [23:0] hd;
    logic [7:0]  m;
    bus.host_wr   = 1'b0;
    bus.host_data = '0;
    for (int c = 0; c < 8; c++) begin ref_tbl[c] = 0; acc[c] = 0; nacc[c] = 0; end
    repeat (3) @(negedge clk);
    check("rst_adc_in_wr",   32'(bus.adc_in_wr), 0);
    check("rst_adc_in_data", 32'(bus.adc_in_data), 0);
    check("rst_host_busy",   32'(bus.host_busy), 0);
    check("rst_host_rsp_wr", 32'(bus.host_rsp_wr), 0);
    check("rst_host_rsp",    32'(bus.host_rsp_data), 0);
    check("rst_scan_done",   32'(scan_done), 0);
    check("rst_err_to",      32'(err_timeout), 0);
    check("rst_err_ov",      32'(err_overrun), 0);
    check("rst_rd_data",     32'(rd_data), 0);
    check("rst_rd_valid",    32'(rd_valid), 0);
    rst = 1'b0;
    @(negedge clk);

    // Two-channel scan with known samples.
    lat = 3;
    force_q.push_back(10'h155);
    force_q.push_back(10'h2AA);
    d0 = done_cnt;
    run_scan(8'h05, "scan05");
    repeat (2) @(negedge clk);
    check("scan05_done_cnt", 32'(done_cnt - d0), 1);
    check_table("scan05");

    // Channel 1 never answers: timeout flagged, channel 2 still scanned.
    silent = 8'h02;
    lat    = 5;
    run_scan(8'h07, "tmo");
    check("tmo_err", 32'(err_timeout), 1);
    check_table("tmo");
    rd_addr = 3'd1;
    @(negedge clk);
    check("tmo_valid1", 32'(rd_valid), 0);
    pulse_clr();
    check("tmo_clr", 32'(err_timeout), 0);
    silent = 8'h00;

    // Host request lands in the same cycle as the scan tick: host goes first.
    lat     = 4;
    ch_mask = 8'h01;
    exp_cmd.push_back(24'h000003);
    push_scan(8'h01);
    enable = 1'b1;
    repeat (PERIOD-1) @(negedge clk);
    bus.host_data = 24'h000003;
    bus.host_wr   = 1'b1;
    @(negedge clk);
    bus.host_wr = 1'b0;
    check("tick_host_busy", 32'(bus.host_busy), 1);
    wait_done("host_tick");
    wait_host("host_tick");

    for (int it = 0; it < 8; it++) begin
      lat = $urandom_range(1, 15);
      if ($urandom_range(0, 1) == 1) begin
        hd = 24'($urandom) & 24'hFFFF7F;
        exp_cmd.push_back(hd);
        bus.host_data = hd;
        bus.host_wr   = 1'b1;
        @(negedge clk);
        bus.host_data = ~hd;
        @(negedge clk);
        bus.host_wr = 1'b0;
        check("rnd_host_busy", 32'(bus.host_busy), 1);
        wait_host("rnd_host");
      end
      m = 8'($urandom);
      run_scan(m, "rnd");
      check_table("rnd");
    end

    // All channels with slow ADC: a tick arrives mid-scan.
    pulse_clr();
    check("ovr_pre", 32'(err_overrun), 0);
    lat = 15;
    run_scan(8'hFF, "ovr");
    check("ovr_err", 32'(err_overrun), 1);
    pulse_clr();
    check("ovr_clr", 32'(err_overrun), 0);

    d0 = done_cnt;
    run_scan(8'h00, "empty");
    repeat (2) @(negedge clk);
    check("empty_done_cnt", 32'(done_cnt - d0), 1);

    lat = 2;
    c0  = cmd_cnt;
    for (int i = 0; i < NCONV; i++) force_q.push_back(10'(100 + i));
    run_scan(8'h10, "avg");
    check("avg_cmds", 32'(cmd_cnt - c0), 32'(NCONV));
    rd_addr = 3'd4;
    @(negedge clk);
    check("avg_tbl4", 32'(rd_data), (NCONV == 4) ? 32'd101 : 32'd100);

    // Reset while waiting on a slow result; the late strobe must be ignored.
    lat     = 15;
    ch_mask = 8'h08;
    push_scan(8'h08);
    c0      = cmd_cnt;
    enable  = 1'b1;
    n       = 0;
    while (cmd_cnt == c0 && n < PERIOD + 20) begin
      @(negedge clk);
      n++;
    end
    check("rstw_issued", 32'(cmd_cnt - c0), 1);
    repeat (3) @(negedge clk);
    rst    = 1'b1;
    epoch++;
    enable = 1'b0;
    exp_cmd.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    ref_vld = 8'h00;
    for (int c = 0; c < 8; c++) begin ref_tbl[c] = 0; acc[c] = 0; nacc[c] = 0; end
    repeat (20) @(negedge clk);
    check("rstw_adc_in_wr", 32'(bus.adc_in_wr), 0);
    check("rstw_host_busy", 32'(bus.host_busy), 0);
    check("rstw_rsp_wr",    32'(bus.host_rsp_wr), 0);
    check("rstw_err_to",    32'(err_timeout), 0);
    check("rstw_err_ov",    32'(err_overrun), 0);
    check_table("rstw");

    check("exp_cmd_left", 32'(exp_cmd.size()), 0);
    check("exp_rsp_left", 32'(exp_rsp.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
